udp_tx_loader: RTL and testbench

- Byte-stream front end for the UDP/IP transmit path. Packs user payload bytes into 32-bit big-endian words and writes them into the transmit RAM that the frame sender reads.
- Computes the UDP length and IP total length for the frame.
- Pulses a start to the sender, then holds off new input until the sender has finished.
- Sits between user logic and the transmit RAM / sender, in the e_rxc domain.

---
 rtl/udp_tx_loader.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_udp_tx_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_loader.sv
// ---------------------------------------------------------------------------
// udp_tx_loader
//
// Byte-stream front end of the UDP/IP transmit path (e_rxc domain).
// Payload bytes are packed big-endian into 32-bit words and written to the
// transmit RAM starting at word 0 for every frame. Once the last byte is in,
// the UDP length (n + 8) and IP total length (n + 28) are latched, a one-cycle
// tx_start is pulsed to the frame sender, and new input is held off until the
// sender has finished (or never acknowledged the start).
//
// Optional feature (macro UDP_TX_CHECKSUM_EN):
//   defined   - tx_payload_sum carries the 16-bit one's-complement sum of the
//               payload taken as big-endian 16-bit words (odd tail padded
//               with 0x00), latched in FLUSH and valid at tx_start.
//   undefined - tx_payload_sum is tied to zero and no adder is built.
//
// Ports:
//   e_rxc           in   clock
//   reset_n         in   asynchronous active-low reset
//   din[7:0]        in   payload byte
//   din_valid       in   din is presented
//   din_last        in   last byte of frame (qualified by din_valid)
//   din_ready       out  byte accepted this cycle when din_valid is high
//   ram_wr_en       out  RAM write strobe
//   ram_wr_addr     out  RAM word address (ADDR_W bits)
//   ram_wr_data     out  packed word, first byte in [31:24]
//   tx_data_length  out  UDP length
//   tx_total_length out  IP total length
//   tx_start        out  one-cycle start pulse to the sender
//   tx_busy         in   sender is transmitting
//   overflow        out  sticky: payload exceeded MAX_BYTES
//   tx_payload_sum  out  payload one's-complement sum (see above)
//   ld_state[2:0]   out  state code for debug
//
// MAX_BYTES must not exceed 4 * 2**ADDR_W, and ADDR_W must be at most 14.
// ---------------------------------------------------------------------------
module udp_tx_loader #(
  parameter int MAX_BYTES = 1472,
  parameter int ADDR_W    = 9
) (
  input  logic              e_rxc,
  input  logic              reset_n,
  input  logic [7:0]        din,
  input  logic              din_valid,
  input  logic              din_last,
  output logic              din_ready,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [31:0]       ram_wr_data,
  output logic [15:0]       tx_data_length,
  output logic [15:0]       tx_total_length,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              overflow,
  output logic [15:0]       tx_payload_sum,
  output logic [2:0]        ld_state
);

  localparam int              CNT_W     = 16;
  localparam logic [CNT_W-1:0] MAX_N    = CNT_W'(MAX_BYTES);
  localparam logic [3:0]      WAIT_LAST = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_FLUSH     = 3'd2,
    S_START     = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_WAIT_DONE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       pack_q, pack_d;
  logic [3:0]        wait_q, wait_d;
  logic              overflow_q, overflow_d;
  logic              din_ready_q, din_ready_d;
  logic              tx_start_q, tx_start_d;
  logic              ram_wr_en_q, ram_wr_en_d;
  logic [ADDR_W-1:0] ram_wr_addr_q, ram_wr_addr_d;
  logic [31:0]       ram_wr_data_q, ram_wr_data_d;
  logic [15:0]       data_len_q, data_len_d;
  logic [15:0]       total_len_q, total_len_d;

  logic              accept_s;
  logic [CNT_W-1:0]  cnt_eff_s;
  logic [31:0]       pack_eff_s;
  logic [31:0]       pack_new_s;

  // din_ready_q is only high in IDLE/LOAD, so accept_s implies one of them.
  assign accept_s   = din_valid && din_ready_q;
  // The first byte of a frame (taken in IDLE) starts from an empty counter
  // and pack register, whatever the previous frame left behind.
  assign cnt_eff_s  = (state_q == S_IDLE) ? {CNT_W{1'b0}} : cnt_q;
  assign pack_eff_s = (state_q == S_IDLE) ? 32'h0000_0000 : pack_q;

  // Next-state, byte packing, RAM write and length computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pack_d        = pack_q;
    wait_d        = wait_q;
    overflow_d    = overflow_q;
    ram_wr_en_d   = 1'b0;
    ram_wr_addr_d = ram_wr_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    data_len_d    = data_len_q;
    total_len_d   = total_len_q;
    pack_new_s    = pack_eff_s;

    if (accept_s) begin
      if (state_q == S_IDLE) begin
        overflow_d = 1'b0;
      end else begin
        overflow_d = overflow_q;
      end

      if (cnt_eff_s < MAX_N) begin
        // Lane 0 of a word starts a fresh word so unused low bytes stay zero.
        case (cnt_eff_s[1:0])
          2'd0:    pack_new_s        = {din, 24'h00_0000};
          2'd1:    pack_new_s[23:16] = din;
          2'd2:    pack_new_s[15:8]  = din;
          default: pack_new_s[7:0]   = din;
        endcase
        pack_d = pack_new_s;
        cnt_d  = cnt_eff_s + 16'd1;
        // Full word, or the final (possibly partial) word of the frame.
        if ((cnt_eff_s[1:0] == 2'd3) || din_last) begin
          ram_wr_en_d   = 1'b1;
          ram_wr_addr_d = cnt_eff_s[ADDR_W+1:2];
          ram_wr_data_d = pack_new_s;
        end else begin
          ram_wr_en_d = 1'b0;
        end
      end else begin
        // Saturated: byte is swallowed; only a pending partial word (possible
        // when MAX_BYTES is not a multiple of 4) still needs writing.
        overflow_d = 1'b1;
        cnt_d      = cnt_eff_s;
        pack_d     = pack_eff_s;
        if (din_last && (cnt_eff_s[1:0] != 2'd0)) begin
          ram_wr_en_d   = 1'b1;
          ram_wr_addr_d = cnt_eff_s[ADDR_W+1:2];
          ram_wr_data_d = pack_eff_s;
        end else begin
          ram_wr_en_d = 1'b0;
        end
      end
    end else begin
      pack_d = pack_q;
    end

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = din_last ? S_FLUSH : S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (accept_s && din_last) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FLUSH: begin
        data_len_d  = cnt_q + 16'd8;
        total_len_d = cnt_q + 16'd28;
        state_d     = S_START;
      end
      S_START: begin
        wait_d  = 4'd0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // Give the sender 16 cycles to acknowledge before giving up.
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_IDLE;
        end else begin
          wait_d  = wait_q + 4'd1;
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered decodes of the next state keep these outputs glitch-free.
    din_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    tx_start_d  = (state_d == S_START);
  end

  // State machine and output registers.
  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      pack_q        <= 32'h0000_0000;
      wait_q        <= 4'd0;
      overflow_q    <= 1'b0;
      din_ready_q   <= 1'b0;
      tx_start_q    <= 1'b0;
      ram_wr_en_q   <= 1'b0;
      ram_wr_addr_q <= {ADDR_W{1'b0}};
      ram_wr_data_q <= 32'h0000_0000;
      data_len_q    <= 16'd0;
      total_len_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pack_q        <= pack_d;
      wait_q        <= wait_d;
      overflow_q    <= overflow_d;
      din_ready_q   <= din_ready_d;
      tx_start_q    <= tx_start_d;
      ram_wr_en_q   <= ram_wr_en_d;
      ram_wr_addr_q <= ram_wr_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      data_len_q    <= data_len_d;
      total_len_q   <= total_len_d;
    end
  end

`ifdef UDP_TX_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic [15:0] sum_out_q, sum_out_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] sum_eff_s;

  // 16-bit one's-complement add with the end-around carry folded back in.
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  assign sum_eff_s = (state_q == S_IDLE) ? 16'h0000 : sum_q;

  // Running payload sum: even-position bytes are held as the high half,
  // odd-position bytes complete a big-endian 16-bit word.
  always_comb begin
    sum_d     = sum_eff_s;
    hi_d      = hi_q;
    sum_out_d = sum_out_q;
    if (accept_s && (cnt_eff_s < MAX_N)) begin
      if (cnt_eff_s[0] == 1'b0) begin
        hi_d = din;
      end else begin
        sum_d = ones_add(sum_eff_s, {hi_q, din});
      end
    end else begin
      hi_d = hi_q;
    end
    if (state_q == S_FLUSH) begin
      if (cnt_q[0]) begin
        sum_out_d = ones_add(sum_q, {hi_q, 8'h00});
      end else begin
        sum_out_d = sum_q;
      end
    end else begin
      sum_out_d = sum_out_q;
    end
  end

  // Checksum registers.
  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      sum_q     <= 16'h0000;
      hi_q      <= 8'h00;
      sum_out_q <= 16'h0000;
    end else begin
      sum_q     <= sum_d;
      hi_q      <= hi_d;
      sum_out_q <= sum_out_d;
    end
  end

  assign tx_payload_sum = sum_out_q;
`else
  assign tx_payload_sum = 16'h0000;
`endif

  assign din_ready       = din_ready_q;
  assign ram_wr_en       = ram_wr_en_q;
  assign ram_wr_addr     = ram_wr_addr_q;
  assign ram_wr_data     = ram_wr_data_q;
  assign tx_data_length  = data_len_q;
  assign tx_total_length = total_len_q;
  assign tx_start        = tx_start_q;
  assign overflow        = overflow_q;
  assign ld_state        = state_q;

endmodule

// File: tb/tb_udp_tx_loader.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for udp_tx_loader.
// Inputs change 2 ns after the rising edge; outputs are checked at the same
// point, so each check sees the values registered at the preceding edge.
// A negedge monitor records RAM writes and tx_start pulses.
// ---------------------------------------------------------------------------
module tb_udp_tx_loader;

  logic        e_rxc = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        din_last = 1'b0;
  logic        tx_busy = 1'b0;
  logic        din_ready;
  logic        ram_wr_en;
  logic [8:0]  ram_wr_addr;
  logic [31:0] ram_wr_data;
  logic [15:0] tx_data_length;
  logic [15:0] tx_total_length;
  logic        tx_start;
  logic        overflow;
  logic [15:0] tx_payload_sum;
  logic [2:0]  ld_state;

`ifdef UDP_TX_CHECKSUM_EN
  localparam logic [31:0] EXP_SUM = 32'h0000_0001;
`else
  localparam logic [31:0] EXP_SUM = 32'h0000_0000;
`endif

  udp_tx_loader #(.MAX_BYTES(1472), .ADDR_W(9)) dut (
    .e_rxc           (e_rxc),
    .reset_n         (reset_n),
    .din             (din),
    .din_valid       (din_valid),
    .din_last        (din_last),
    .din_ready       (din_ready),
    .ram_wr_en       (ram_wr_en),
    .ram_wr_addr     (ram_wr_addr),
    .ram_wr_data     (ram_wr_data),
    .tx_data_length  (tx_data_length),
    .tx_total_length (tx_total_length),
    .tx_start        (tx_start),
    .tx_busy         (tx_busy),
    .overflow        (overflow),
    .tx_payload_sum  (tx_payload_sum),
    .ld_state        (ld_state)
  );

  always #5 e_rxc = ~e_rxc;

  logic [31:0] mem [0:511];
  int          wr_count = 0;
  int          start_count = 0;
  logic [8:0]  last_addr = 9'd0;

  // Record RAM writes and start pulses.
  always @(negedge e_rxc) begin
    if (ram_wr_en) begin
      mem[ram_wr_addr] <= ram_wr_data;
      wr_count         <= wr_count + 1;
      last_addr        <= ram_wr_addr;
    end
    if (tx_start) begin
      start_count <= start_count + 1;
    end
  end

  // Run-time bound.
  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before 400000 ns");
    $fatal(1, "watchdog expired");
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge e_rxc);
    #2;
  endtask

  task automatic put(input logic [7:0] b, input logic last);
    din       = b;
    din_valid = 1'b1;
    din_last  = last;
    tick();
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int k;
    k = 0;
    while ((ld_state !== 3'd0) && (k < max_cycles)) begin
      tick();
      k++;
    end
    chk(tag, 32'(ld_state), 32'd0);
  endtask

  initial begin
    int ws;
    int ss;
    int bad;

    // ---------------- reset state ----------------
    #12;
    chk("rst_din_ready", 32'(din_ready), 32'd0);
    chk("rst_wr_en",     32'(ram_wr_en), 32'd0);
    chk("rst_wr_addr",   32'(ram_wr_addr), 32'd0);
    chk("rst_wr_data",   ram_wr_data, 32'd0);
    chk("rst_data_len",  32'(tx_data_length), 32'd0);
    chk("rst_total_len", 32'(tx_total_length), 32'd0);
    chk("rst_start",     32'(tx_start), 32'd0);
    chk("rst_overflow",  32'(overflow), 32'd0);
    chk("rst_sum",       32'(tx_payload_sum), 32'd0);
    chk("rst_state",     32'(ld_state), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_ready", 32'(din_ready), 32'd1);

    // ---------------- frame 1: 01..08, sender never answers ----------------
    ws = wr_count;
    ss = start_count;
    for (int i = 1; i <= 8; i++) begin
      put(8'(i), (i == 8));
    end
    chk("f1_state_flush", 32'(ld_state), 32'd2);
    chk("f1_wr_en",       32'(ram_wr_en), 32'd1);
    chk("f1_wr_addr",     32'(ram_wr_addr), 32'd1);
    chk("f1_wr_data",     ram_wr_data, 32'h0506_0708);
    chk("f1_ready_flush", 32'(din_ready), 32'd0);
    chk("f1_no_start_yet", 32'(tx_start), 32'd0);
    tick();
    chk("f1_start",     32'(tx_start), 32'd1);
    chk("f1_data_len",  32'(tx_data_length), 32'd16);
    chk("f1_total_len", 32'(tx_total_length), 32'd36);
    tick();
    chk("f1_start_gone", 32'(tx_start), 32'd0);
    chk("f1_wait_busy",  32'(ld_state), 32'd4);
    chk("f1_wr_count",   32'(wr_count - ws), 32'd2);
    chk("f1_mem0",       mem[0], 32'h0102_0304);
    chk("f1_mem1",       mem[1], 32'h0506_0708);
    chk("f1_start_cnt",  32'(start_count - ss), 32'd1);
    for (int k = 0; k < 15; k++) tick();
    chk("f1_still_wait", 32'(ld_state), 32'd4);
    chk("f1_wait_ready", 32'(din_ready), 32'd0);
    tick();
    chk("f1_timeout_idle",  32'(ld_state), 32'd0);
    chk("f1_timeout_ready", 32'(din_ready), 32'd1);

    // ---------------- din_last without din_valid in IDLE ----------------
    din_last = 1'b1;
    tick();
    tick();
    din_last = 1'b0;
    chk("lone_last_idle", 32'(ld_state), 32'd0);

    // ---------------- frame 2: AA..EE, busy handshake ----------------
    ws = wr_count;
    ss = start_count;
    put(8'hAA, 1'b0);
    put(8'hBB, 1'b0);
    din_last = 1'b1;
    tick();
    din_last = 1'b0;
    chk("lone_last_load", 32'(ld_state), 32'd1);
    put(8'hCC, 1'b0);
    put(8'hDD, 1'b0);
    put(8'hEE, 1'b1);
    chk("f2_wr_en",   32'(ram_wr_en), 32'd1);
    chk("f2_wr_addr", 32'(ram_wr_addr), 32'd1);
    chk("f2_wr_data", ram_wr_data, 32'hEE00_0000);
    tick();
    chk("f2_start",     32'(tx_start), 32'd1);
    chk("f2_data_len",  32'(tx_data_length), 32'd13);
    chk("f2_total_len", 32'(tx_total_length), 32'd33);
    tick();
    tick();
    tick();
    tx_busy = 1'b1;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (din_ready !== 1'b0) bad++;
    end
    tx_busy = 1'b0;
    chk("f2_ready_low_while_busy", 32'(bad), 32'd0);
    chk("f2_wait_done",  32'(ld_state), 32'd5);
    chk("f2_ready_fall", 32'(din_ready), 32'd0);
    tick();
    chk("f2_ready_after_busy", 32'(din_ready), 32'd1);
    chk("f2_idle",       32'(ld_state), 32'd0);
    chk("f2_wr_count",   32'(wr_count - ws), 32'd2);
    chk("f2_mem0",       mem[0], 32'hAABB_CCDD);
    chk("f2_mem1",       mem[1], 32'hEE00_0000);
    chk("f2_start_cnt",  32'(start_count - ss), 32'd1);

    // ---------------- frame 3: single byte with din_last in IDLE ----------------
    ws = wr_count;
    ss = start_count;
    put(8'h5A, 1'b1);
    chk("f3_state_flush", 32'(ld_state), 32'd2);
    chk("f3_wr_addr",     32'(ram_wr_addr), 32'd0);
    chk("f3_wr_data",     ram_wr_data, 32'h5A00_0000);
    tick();
    chk("f3_start",     32'(tx_start), 32'd1);
    chk("f3_data_len",  32'(tx_data_length), 32'd9);
    chk("f3_total_len", 32'(tx_total_length), 32'd29);
    wait_idle("f3_back_idle", 40);
    chk("f3_wr_count",  32'(wr_count - ws), 32'd1);
    chk("f3_start_cnt", 32'(start_count - ss), 32'd1);

    // ---------------- frame 4: 1480 bytes, overflow ----------------
    ws = wr_count;
    for (int i = 0; i < 1480; i++) begin
      put(8'(i), (i == 1479));
      if (i == 1471) chk("f4_no_overflow_at_max", 32'(overflow), 32'd0);
      if (i == 1472) chk("f4_overflow_set", 32'(overflow), 32'd1);
    end
    tick();
    chk("f4_start",     32'(tx_start), 32'd1);
    chk("f4_overflow",  32'(overflow), 32'd1);
    chk("f4_data_len",  32'(tx_data_length), 32'd1480);
    chk("f4_total_len", 32'(tx_total_length), 32'd1500);
    wait_idle("f4_back_idle", 40);
    chk("f4_wr_count",  32'(wr_count - ws), 32'd368);
    chk("f4_last_addr", 32'(last_addr), 32'd367);
    chk("f4_mem0",      mem[0], 32'h0001_0203);
    chk("f4_mem367",    mem[367], 32'hBCBD_BEBF);
    chk("f4_overflow_sticky", 32'(overflow), 32'd1);

    // ---------------- frame 5: FF FF 00 01 ----------------
    put(8'hFF, 1'b0);
    chk("f5_overflow_cleared", 32'(overflow), 32'd0);
    put(8'hFF, 1'b0);
    put(8'h00, 1'b0);
    put(8'h01, 1'b1);
    chk("f5_wr_addr", 32'(ram_wr_addr), 32'd0);
    chk("f5_wr_data", ram_wr_data, 32'hFFFF_0001);
    tick();
    chk("f5_start",     32'(tx_start), 32'd1);
    chk("f5_data_len",  32'(tx_data_length), 32'd12);
    chk("f5_total_len", 32'(tx_total_length), 32'd32);
    chk("f5_sum",       32'(tx_payload_sum), EXP_SUM);
    wait_idle("f5_back_idle", 40);

    // ---------------- frame 6: reset mid-frame ----------------
    ss = start_count;
    put(8'h11, 1'b0);
    put(8'h22, 1'b0);
    put(8'h33, 1'b0);
    chk("f6_loading", 32'(ld_state), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("f6_rst_state",     32'(ld_state), 32'd0);
    chk("f6_rst_ready",     32'(din_ready), 32'd0);
    chk("f6_rst_wr_en",     32'(ram_wr_en), 32'd0);
    chk("f6_rst_wr_addr",   32'(ram_wr_addr), 32'd0);
    chk("f6_rst_wr_data",   ram_wr_data, 32'd0);
    chk("f6_rst_data_len",  32'(tx_data_length), 32'd0);
    chk("f6_rst_total_len", 32'(tx_total_length), 32'd0);
    chk("f6_rst_overflow",  32'(overflow), 32'd0);
    chk("f6_rst_sum",       32'(tx_payload_sum), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 30; k++) tick();
    chk("f6_no_start", 32'(start_count - ss), 32'd0);
    chk("f6_idle",     32'(ld_state), 32'd0);
    chk("f6_ready",    32'(din_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
